// File: rtl/up_counter_ctrl.sv
// Sequencing controller for the 8-bit up counter: turns a start command into
// load/enable strobes, with prescaling, pause, one-shot or auto-reload.
module up_counter_ctrl (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Pause,
  input  logic       Mode,
  input  logic [7:0] StartVal,
  input  logic [7:0] EndVal,
  input  logic [7:0] Prescale,
  input  logic [7:0] Count,
  output logic       Load,
  output logic [7:0] LoadVal,
  output logic       Enable,
  output logic       Busy,
  output logic       Done,
  output logic       Wrap,
  output logic [7:0] WrapCnt,
  output logic       Err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic       mode_q;
  logic [7:0] start_q, end_q, pre_q;
  logic [7:0] pcnt;
  logic [7:0] wrap_cnt;
  logic       err_q;

  logic idle_like, start_ok, start_bad, tick, at_end;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign start_ok  = idle_like && Start && !Stop && (StartVal <= EndVal);
  assign start_bad = idle_like && Start && !Stop && (EndVal < StartVal);
  assign tick      = (state == RUN) && (pcnt == 8'd0) && !Pause;
  assign at_end    = (Count == end_q);

  // NOTE: every output and next-state term gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    Load      = 1'b0;
    Enable    = 1'b0;
    Wrap      = 1'b0;
    if (Stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start_ok) state_nxt = LOAD;
        LOAD: begin
          Load      = 1'b1;
          state_nxt = RUN;
        end
        RUN: begin
          if (tick) begin
            if (!at_end) begin
              Enable = 1'b1;
            end else if (mode_q) begin
              Load = 1'b1;
              Wrap = 1'b1;
            end else begin
              state_nxt = DONE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mode_q   <= 1'b0;
      start_q  <= 8'd0;
      end_q    <= 8'd0;
      pre_q    <= 8'd0;
      pcnt     <= 8'd0;
      wrap_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= start_bad;
      if (start_ok) begin
        mode_q   <= Mode;
        start_q  <= StartVal;
        end_q    <= EndVal;
        pre_q    <= Prescale;
        wrap_cnt <= 8'd0;
      end
      if (Wrap && (wrap_cnt != 8'hFF)) wrap_cnt <= wrap_cnt + 8'd1;
      // Stop freezes the prescaler along with the captured command.
      if (!Stop) begin
        if (state == LOAD) begin
          pcnt <= 8'd0;
        end else if ((state == RUN) && !Pause) begin
          pcnt <= (pcnt == 8'd0) ? pre_q : pcnt - 8'd1;
        end
      end
    end
  end

  assign LoadVal = start_q;
  assign Busy    = (state == LOAD) || (state == RUN);
  assign Done    = (state == DONE);
  assign WrapCnt = wrap_cnt;
  assign Err     = err_q;

endmodule
